// File: rtl/dmem_responder_if.sv
// Load/store bus between a requester and dmem_responder.
// Request fields flow to the responder; the registered response flows back.
interface dmem_responder_if #(
    parameter int ADDR_W = 7
) ();
    logic              d_req;
    logic              d_we;
    logic              d_be;
    logic              d_he;
    logic [ADDR_W-1:0] daddr;
    logic [31:0]       dwdata;
    logic [31:0]       drdata;
    logic              d_ready;
    logic              d_err;

    modport master (
        output d_req, d_we, d_be, d_he, daddr, dwdata,
        input  drdata, d_ready, d_err
    );

    modport slave (
        input  d_req, d_we, d_be, d_he, daddr, dwdata,
        output drdata, d_ready, d_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder with byte/half/word access and misalignment error; DMEM_LOAD_SEXT_EN sign-extends sub-word loads.
// Latency: d_ready is sampled WAIT_CYCLES+1 edges after the accept edge; one-cycle registered response strobe.
// Backpressure: one access in flight; d_req is only sampled in IDLE, so the requester holds it until accepted.
module dmem_responder #(
    parameter int ADDR_W      = 7,
    parameter int WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);
    localparam int         WIDX_W  = ADDR_W - 2;
    localparam int         DEPTH   = 1 << WIDX_W;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
    typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    size_t             size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              d_ready_q, d_ready_d;
    logic              d_err_q, d_err_d;
    logic [31:0]       drdata_q, drdata_d;

    logic [31:0]       mem_q [DEPTH];

    size_t             in_size;
    logic              acc_we;
    size_t             acc_size;
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_mis;
    logic [31:0]       acc_word;
    logic [31:0]       load_val;
    logic [7:0]        load_byte;
    logic [15:0]       load_half;
    logic              resp_go;
    logic              mem_we;
    logic [31:0]       mem_wword;

    always_comb begin
        if (bus.d_be)      in_size = SZ_BYTE;
        else if (bus.d_he) in_size = SZ_HALF;
        else               in_size = SZ_WORD;
    end

    // In IDLE the live inputs are used so a zero-wait access can respond on its accept edge.
    always_comb begin
        acc_we   = we_q;
        acc_size = size_q;
        acc_addr = addr_q;
        if (state_q == ST_IDLE) begin
            acc_we   = bus.d_we;
            acc_size = in_size;
            acc_addr = bus.daddr;
        end
    end

    always_comb begin
        acc_mis = 1'b0;
        case (acc_size)
            SZ_HALF: acc_mis = acc_addr[0];
            SZ_WORD: acc_mis = |acc_addr[1:0];
            default: acc_mis = 1'b0;
        endcase
    end

    assign acc_word  = mem_q[acc_addr[ADDR_W-1:2]];
    assign load_byte = acc_word[{acc_addr[1:0], 3'b000} +: 8];
    assign load_half = acc_addr[1] ? acc_word[31:16] : acc_word[15:0];

    always_comb begin
        case (acc_size)
`ifdef DMEM_LOAD_SEXT_EN
            SZ_BYTE: load_val = {{24{load_byte[7]}}, load_byte};
            SZ_HALF: load_val = {{16{load_half[15]}}, load_half};
`else
            SZ_BYTE: load_val = {24'h0, load_byte};
            SZ_HALF: load_val = {16'h0, load_half};
`endif
            default: load_val = acc_word;
        endcase
    end

    // Store merge: read-modify-write of the addressed word, committed on the edge that ends RESP.
    always_comb begin
        mem_wword = acc_word;
        case (size_q)
            SZ_BYTE: mem_wword[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            SZ_HALF: begin
                if (addr_q[1]) mem_wword[31:16] = wdata_q[15:0];
                else           mem_wword[15:0]  = wdata_q[15:0];
            end
            default: mem_wword = wdata_q;
        endcase
    end

    assign mem_we = (state_q == ST_RESP) && we_q && !acc_mis;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        resp_go   = 1'b0;
        d_ready_d = 1'b0;
        d_err_d   = 1'b0;
        drdata_d  = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (bus.d_req) begin
                    we_d    = bus.d_we;
                    size_d  = in_size;
                    addr_d  = bus.daddr;
                    wdata_d = bus.dwdata;
                    cnt_d   = WAIT_LD;
                    if (WAIT_LD != 4'd0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                        resp_go = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    resp_go = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (resp_go) begin
            d_ready_d = 1'b1;
            d_err_d   = acc_mis;
            drdata_d  = (acc_we || acc_mis) ? 32'h0 : load_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            size_q    <= SZ_WORD;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            d_ready_q <= 1'b0;
            d_err_q   <= 1'b0;
            drdata_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            d_ready_q <= d_ready_d;
            d_err_q   <= d_err_d;
            drdata_q  <= drdata_d;
        end
    end

    // RAM contents survive reset; an aborted access never reaches RESP, so it never writes.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q[ADDR_W-1:2]] <= mem_wword;
        end
    end

    assign bus.d_ready = d_ready_q;
    assign bus.d_err   = d_err_q;
    assign bus.drdata  = drdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: two instances (1 and 3 wait states), directed accesses,
// expected responses queued at issue and checked by a monitor on each d_ready.
`timescale 1ns/1ps
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   tag_n = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
        int          tag;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

`ifdef DMEM_LOAD_SEXT_EN
    localparam logic [31:0] EXP_H8001 = 32'hFFFF8001;
    localparam logic [31:0] EXP_BAA   = 32'hFFFFFFAA;
    localparam logic [31:0] EXP_B80   = 32'hFFFFFF80;
`else
    localparam logic [31:0] EXP_H8001 = 32'h00008001;
    localparam logic [31:0] EXP_BAA   = 32'h000000AA;
    localparam logic [31:0] EXP_B80   = 32'h00000080;
`endif

    dmem_responder_if #(.ADDR_W(7)) if1 ();
    dmem_responder_if #(.ADDR_W(7)) if3 ();

    dmem_responder #(.ADDR_W(7), .WAIT_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    dmem_responder #(.ADDR_W(7), .WAIT_CYCLES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input int which, input logic req, input logic we, input logic be,
                         input logic he, input logic [6:0] addr, input logic [31:0] wd);
        if (which == 1) begin
            if1.d_req = req; if1.d_we = we; if1.d_be = be; if1.d_he = he;
            if1.daddr = addr; if1.dwdata = wd;
        end else begin
            if3.d_req = req; if3.d_we = we; if3.d_be = be; if3.d_he = he;
            if3.daddr = addr; if3.dwdata = wd;
        end
    endtask

    function automatic logic ready_of(input int which);
        return (which == 1) ? if1.d_ready : if3.d_ready;
    endfunction

    task automatic push_exp(input int which, input logic [31:0] d, input logic e, input int due);
        exp_t x;
        x.data = d; x.err = e; x.due = due; x.tag = tag_n;
        tag_n++;
        if (which == 1) q1.push_back(x);
        else            q3.push_back(x);
    endtask

    task automatic check_resp(input int which, input logic [31:0] d, input logic e);
        exp_t x;
        if ((which == 1 && q1.size() == 0) || (which == 3 && q3.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected d_ready dut%0d at cycle %0d: got drdata %h err %b, required no response",
                     which, cyc, d, e);
            return;
        end
        x = (which == 1) ? q1.pop_front() : q3.pop_front();
        chk($sformatf("dut%0d tag%0d drdata", which, x.tag), d, x.data);
        chk($sformatf("dut%0d tag%0d d_err", which, x.tag), {31'h0, e}, {31'h0, x.err});
        chk($sformatf("dut%0d tag%0d response cycle", which, x.tag), cyc, x.due);
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (if1.d_ready) check_resp(1, if1.drdata, if1.d_err);
            if (if3.d_ready) check_resp(3, if3.drdata, if3.d_err);
        end
    endtask

    // One complete access: drive for the accept edge, queue the expectation, wait for d_ready.
    task automatic xact(input int which, input logic we, input logic be, input logic he,
                        input logic [6:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e);
        int n;
        @(negedge clk);
        drive(which, 1'b1, we, be, he, addr, wd);
        push_exp(which, exp_d, exp_e, cyc + 1 + ((which == 1) ? 1 : 3));
        @(posedge clk);
        @(negedge clk);
        drive(which, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        n = 0;
        while (!ready_of(which) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL timeout dut%0d addr %h: no d_ready within 20 cycles, required one", which, addr);
        end
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, " dut1 ready/err"}, {30'h0, if1.d_ready, if1.d_err}, 32'h0);
        chk({tag, " dut1 drdata"}, if1.drdata, 32'h0);
        chk({tag, " dut3 ready/err"}, {30'h0, if3.d_ready, if3.d_err}, 32'h0);
        chk({tag, " dut3 drdata"}, if3.drdata, 32'h0);
    endtask

    initial begin
        int n0;
        rst = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        fork
            monitor();
        join_none

        repeat (3) begin
            @(negedge clk);
            idle_checks("in reset");
        end
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            idle_checks("idle after reset");
        end

        // word round trip, lanes, priority and misalignment on the 1-wait instance
        xact(1, 1'b1, 1'b0, 1'b0, 7'h10, 32'hDEADBEEF, 32'h0, 1'b0);
        xact(1, 1'b0, 1'b0, 1'b0, 7'h10, 32'h0, 32'hDEADBEEF, 1'b0);
        xact(1, 1'b1, 1'b0, 1'b0, 7'h20, 32'h11223344, 32'h0, 1'b0);
        xact(1, 1'b1, 1'b1, 1'b0, 7'h22, 32'h123456AA, 32'h0, 1'b0);
        xact(1, 1'b1, 1'b0, 1'b1, 7'h20, 32'hABCD8001, 32'h0, 1'b0);
        xact(1, 1'b0, 1'b0, 1'b0, 7'h20, 32'h0, 32'h11AA8001, 1'b0);
        xact(1, 1'b0, 1'b1, 1'b0, 7'h23, 32'h0, 32'h00000011, 1'b0);
        xact(1, 1'b0, 1'b0, 1'b1, 7'h20, 32'h0, EXP_H8001, 1'b0);
        xact(1, 1'b0, 1'b1, 1'b0, 7'h22, 32'h0, EXP_BAA, 1'b0);
        xact(1, 1'b0, 1'b0, 1'b1, 7'h22, 32'h0, 32'h000011AA, 1'b0);
        xact(1, 1'b0, 1'b1, 1'b1, 7'h21, 32'h0, EXP_B80, 1'b0);
        xact(1, 1'b1, 1'b0, 1'b0, 7'h21, 32'h12345678, 32'h0, 1'b1);
        xact(1, 1'b1, 1'b0, 1'b1, 7'h21, 32'h0000FFFF, 32'h0, 1'b1);
        xact(1, 1'b0, 1'b0, 1'b0, 7'h20, 32'h0, 32'h11AA8001, 1'b0);
        xact(1, 1'b0, 1'b0, 1'b1, 7'h23, 32'h0, 32'h0, 1'b1);
        xact(1, 1'b0, 1'b0, 1'b0, 7'h22, 32'h0, 32'h0, 1'b1);

        // reset landing inside a RESP cycle must clear the outputs at once
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h10, 32'h0);
        @(posedge clk);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        @(posedge clk);
        #1;
        chk("dut1 in RESP before abort", {31'h0, if1.d_ready}, 32'h1);
        #1;
        rst = 1'b0;
        #1;
        chk("async reset d_ready/d_err", {30'h0, if1.d_ready, if1.d_err}, 32'h0);
        chk("async reset drdata", if1.drdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // 3-wait instance: baseline contents
        xact(3, 1'b1, 1'b0, 1'b0, 7'h30, 32'hCAFEF00D, 32'h0, 1'b0);
        xact(3, 1'b0, 1'b0, 1'b0, 7'h30, 32'h0, 32'hCAFEF00D, 1'b0);

        // d_req held high: accepts every 5 cycles
        @(negedge clk);
        n0 = cyc;
        drive(3, 1'b1, 1'b0, 1'b0, 1'b0, 7'h30, 32'h0);
        for (int k = 0; k < 3; k++) push_exp(3, 32'hCAFEF00D, 1'b0, n0 + 4 + 5 * k);
        repeat (11) @(negedge clk);
        drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        repeat (6) @(negedge clk);

        // d_req toggling with a conflicting store during WAIT is ignored
        n0 = cyc;
        drive(3, 1'b1, 1'b0, 1'b0, 1'b0, 7'h30, 32'h0);
        push_exp(3, 32'hCAFEF00D, 1'b0, n0 + 4);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 1'b0, 1'b0, 7'h30, 32'h00000BAD);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        repeat (4) @(negedge clk);
        xact(3, 1'b0, 1'b0, 1'b0, 7'h30, 32'h0, 32'hCAFEF00D, 1'b0);

        // reset during WAIT aborts a store: no response, no write
        @(negedge clk);
        drive(3, 1'b1, 1'b1, 1'b0, 1'b0, 7'h30, 32'h00000055);
        @(posedge clk);
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 1'b0, 1'b0, 7'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset in WAIT d_ready", {31'h0, if3.d_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        xact(3, 1'b0, 1'b0, 1'b0, 7'h30, 32'h0, 32'hCAFEF00D, 1'b0);

        repeat (5) @(negedge clk);
        chk("dut1 responses outstanding", q1.size(), 32'h0);
        chk("dut3 responses outstanding", q3.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the rv32i_core load/store interface (d_we, daddr, dwdata, drdata).
- Adds a request/ready handshake, byte/half/word access sizes, configurable wait states and a misalignment error.
- Holds the word-organised data RAM.
- Replaces the zero-latency data memory so the core can be verified against a slow memory.

Parameters:
- ADDR_W, 7, byte-address width; RAM depth = 2^(ADDR_W-2) 32-bit words.
- WAIT_CYCLES, 1, extra cycles between accept and response (0..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- d_req  input  1  request valid; sampled only in IDLE.
- d_we  input  1  1 = store, 0 = load.
- d_be  input  1  byte access.
- d_he  input  1  halfword access.
- daddr  input  ADDR_W  byte address.
- dwdata  input  32  store data, right-justified.
- drdata  output  32  load data, right-justified.
- d_ready  output  1  one-cycle response strobe.
- d_err  output  1  misaligned access; valid with d_ready.

Behaviour:
- Reset (rst=0, asynchronous):
  - state goes to IDLE; counter clears to 0.
  - d_ready=0, d_err=0, drdata=0.
  - RAM contents are not reset.
  - Reset asserted mid-WAIT or mid-RESP aborts the access; no RAM write occurs.
- Access size:
  - d_be=1 selects byte. d_be has priority, so d_be=1 with d_he=1 is a byte access.
  - else d_he=1 selects halfword.
  - else word.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - d_req=1 accepts the request: latch d_we, size, daddr and dwdata.
  - Counter loads WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: counter decrements each cycle; when it reaches 1, next state is RESP.
- RESP:
  - Lasts exactly one cycle with d_ready=1; next state is always IDLE.
  - Response latency = WAIT_CYCLES+1 cycles after the accept edge.
  - A request asserted during RESP is not accepted. d_req still high in the following IDLE cycle is accepted as a new request, so the requester deasserts d_req on seeing d_ready.
- Inputs outside IDLE are ignored. Latched values are used for the whole access.
- Misalignment:
  - Halfword with addr[0]=1, or word with addr[1:0]!=0, is misaligned.
  - Response: d_err=1 with d_ready=1, no RAM write, drdata=0.
- Stores (aligned, committed on the RESP clock edge):
  - word: full word.
  - half: 16-bit lane selected by addr[1]; other lane unchanged.
  - byte: lane addr[1:0]; other bytes unchanged.
  - Word index = addr[ADDR_W-1:2].
- Loads:
  - drdata is registered and valid only during RESP.
  - Byte/half is right-justified from its lane, zero-extended (see optional feature).
  - Store responses return drdata=0.
  - Outside RESP, drdata holds 0.
- d_ready and d_err are registered outputs: no combinational path from any input.

Optional Feature:
- Macro: DMEM_LOAD_SEXT_EN.
- Defined: byte loads are sign-extended from bit 7 and halfword loads from bit 15.
- Undefined: byte and halfword loads are zero-extended.
- Word loads and all stores are identical in both builds.

Test Plan:
- Reset/idle: rst=0 for 3 cycles, then release; d_req=0 for 5 cycles -> d_ready=0, d_err=0, drdata=0 throughout, including immediately on the asynchronous assertion.
- Word round trip (WAIT_CYCLES=1):
  - Store 0xDEADBEEF at 0x10 -> d_ready one cycle, 2 cycles after the accept edge.
  - Load 0x10 -> drdata=0xDEADBEEF with d_ready, d_err=0.
- Byte/half lanes:
  - Store word 0x11223344 at 0x20, then byte 0xAA at 0x22, then half 0x8001 at 0x20.
  - Word load of 0x20 -> 0x11AA8001.
  - Byte load of 0x23 -> 0x00000011.
  - Half load of 0x20 -> 0x00008001 without the macro, 0xFFFF8001 with DMEM_LOAD_SEXT_EN.
- Misalignment:
  - Word store 0x12345678 at 0x21 -> d_err=1 with d_ready.
  - A following word load of 0x20 returns the unchanged value.
  - Half load at 0x23 -> d_err=1, drdata=0.
- Wait states and back-to-back (WAIT_CYCLES=3):
  - Hold d_req high continuously -> accepts spaced exactly 5 cycles apart.
  - d_ready pulses one cycle each time; d_req toggles in WAIT are ignored.
- Reset mid-access: issue store 0x55 to 0x30, then assert rst during WAIT -> no d_ready, and a later load of 0x30 returns the prior contents.
